alu_shift_add_multiplier: RTL and testbench

//   Sequential unsigned multiplier for the ALU. It consumes the ripple adder built from FULL_ADDER cells.

---
 rtl/alu_shift_add_multiplier_pkg.sv | 12 +
 rtl/alu_shift_add_multiplier_if.sv | 14 +
 rtl/full_adder.sv | 11 +
 rtl/ripple_adder.sv | 25 ++
 rtl/alu_shift_add_multiplier.sv | 85 ++++++++
 tb/tb_alu_shift_add_multiplier.sv | 140 ++++++++++++++
 6 files changed

// File: rtl/alu_shift_add_multiplier_pkg.sv
// Shared ALU definitions: default operand width and multiplier FSM state encodings.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_shift_add_multiplier_if.sv
// Request/response bundle between ALU control (master) and the shift-add multiplier (slave).
interface alu_shift_add_multiplier_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/ripple_adder.sv
// Combinational WIDTH-bit ripple-carry adder built from chained full_adder cells, carry-in tied low.
module ripple_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .c_i  (carry[i]),
      .s_o  (sum_o[i]),
      .co_o (carry[i+1])
    );
  end

  assign cout_o = carry[WIDTH];
endmodule

// File: rtl/alu_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: WIDTH add/shift cycles, then a one-cycle done pulse.
module alu_shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input logic                        clk,
  input logic                        rst_n,
  alu_shift_add_multiplier_if.slave  mul_if
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;

  assign addend = acc_q[0] ? mcand_q : '0;

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i    (acc_q[2*WIDTH-1:WIDTH]),
    .b_i    (addend),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        // Operands are only looked at here, so X on a/b elsewhere never reaches state.
        if (mul_if.start) begin
          state_d = ST_RUN;
          mcand_d = mul_if.a;
          acc_d   = {{WIDTH{1'b0}}, mul_if.b};
          count_d = '0;
        end
      end
      ST_RUN: begin
        // Carry shifts into the top bit, so no product bit is lost.
        acc_d   = {cout, sum, acc_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d   = ST_DONE;
          product_d = acc_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign mul_if.busy    = (state_q != ST_IDLE);
  assign mul_if.done    = (state_q == ST_DONE);
  assign mul_if.product = product_q;

endmodule

// File: tb/tb_alu_shift_add_multiplier.sv
// Directed bench for alu_shift_add_multiplier at WIDTH=8.
module tb_alu_shift_add_multiplier;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_shift_add_multiplier_if #(.WIDTH(W)) mul_if ();

  alu_shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mul_if (mul_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation from IDLE; observes W+4 cycles. inj>0 pulses start with 7*7 at that cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input int inj, input string tag);
    int done_cyc = -1;
    int n_done   = 0;
    logic [2*W-1:0] prod = '0;
    logic busy_after = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b1;
    mul_if.a     = a;
    mul_if.b     = b;
    for (int k = 1; k <= int'(W) + 4; k++) begin
      @(negedge clk);
      if (k == inj) begin
        mul_if.start = 1'b1;
        mul_if.a     = 8'd7;
        mul_if.b     = 8'd7;
      end else begin
        mul_if.start = 1'b0;
        mul_if.a     = 'x;
        mul_if.b     = 'x;
      end
      if (mul_if.done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k;
          prod     = mul_if.product;
        end
      end
      if (done_cyc > 0 && k == done_cyc + 1) busy_after = mul_if.busy;
    end
    mul_if.start = 1'b0;
    check_eq({tag, ".ndone"}, n_done, 1);
    check_eq({tag, ".lat"}, done_cyc, W + 1);
    check_eq({tag, ".prod"}, {16'h0, prod}, {16'h0, exp});
    check_eq({tag, ".busy_after"}, {31'h0, busy_after}, 0);
  endtask

  initial begin
    logic [2*W-1:0] expq[$];
    int n_done;

    mul_if.start = 1'b0;
    mul_if.a     = '0;
    mul_if.b     = '0;

    // Reset hold
    repeat (2) @(negedge clk);
    check_eq("rst.busy", mul_if.busy, 0);
    check_eq("rst.done", mul_if.done, 0);
    check_eq("rst.prod", mul_if.product, 0);
    rst_n = 1'b1;
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (mul_if.done || mul_if.busy) n_done++;
    end
    check_eq("rst.idle_quiet", n_done, 0);

    do_op(8'd13, 8'd11, 16'd143, 0, "basic");
    do_op(8'hFF, 8'hFF, 16'hFE01, 0, "max");
    do_op(8'd0, 8'hA5, 16'd0, 0, "zero_a");
    do_op(8'h5A, 8'd0, 16'd0, 0, "zero_b");
    do_op(8'd3, 8'd4, 16'd12, 3, "busy_ign");

    // Mid-op reset: product from last op is 12, must clear asynchronously
    @(negedge clk);
    mul_if.start = 1'b1;
    mul_if.a     = 8'd9;
    mul_if.b     = 8'd9;
    @(negedge clk);
    mul_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst.busy", mul_if.busy, 0);
    check_eq("midrst.done", mul_if.done, 0);
    check_eq("midrst.prod", mul_if.product, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (mul_if.done) n_done++;
    end
    check_eq("midrst.no_done", n_done, 0);
    do_op(8'd9, 8'd9, 16'd81, 0, "after_rst");

    // Back-to-back with start held: accepts every W+2 cycles, done at t%(W+2)==W+1
    @(negedge clk);
    mul_if.start = 1'b1;
    for (int t = 0; t < 20 * int'(W + 2); t++) begin
      if (t > 0) @(negedge clk);
      if (t > 0 && (t % int'(W + 2)) == int'(W + 1)) begin
        check_eq("b2b.done", mul_if.done, 1);
        if (expq.size() == 0) check_eq("b2b.queue", 0, 1);
        else check_eq("b2b.prod", mul_if.product, expq.pop_front());
      end else if (mul_if.done) begin
        check_eq("b2b.spurious_done", mul_if.done, 0);
      end
      mul_if.a = W'($urandom_range(0, 255));
      mul_if.b = W'($urandom_range(0, 255));
      if ((t % int'(W + 2)) == 0) expq.push_back(16'(mul_if.a) * 16'(mul_if.b));
    end
    mul_if.start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
